// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring bus decoder: FSM state, rotate,
// one-hot to index conversion and a clog2 that never returns zero.
package ring_pkg;

  localparam int MAX_W = 64;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } ring_state_e;

  function automatic int clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Patterns are zero-extended to MAX_W; the mask keeps the rotate within width bits.
  function automatic logic [MAX_W-1:0] rotate(input logic [MAX_W-1:0] pattern,
                                               input int width,
                                               input logic rot_left);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] res;
    mask = (MAX_W'(1) << width) - MAX_W'(1);
    if (rot_left)
      res = (pattern << 1) | (pattern >> (width - 1));
    else
      res = (pattern >> 1) | (pattern << (width - 1));
    return res & mask;
  endfunction

  function automatic int onehot_idx(input logic [MAX_W-1:0] pattern);
    int pos;
    pos = 0;
    for (int i = 0; i < MAX_W; i++)
      if (pattern[i]) pos = i;
    return pos;
  endfunction

endpackage

// File: rtl/ring_onehot_enc.sv
// Combinational one-hot to binary encoder with a legality flag
// (legal means exactly one bit set).
module ring_onehot_enc
  import ring_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IDX_W = 2
) (
  input  logic [WIDTH-1:0] pattern_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             legal_o
);

  assign legal_o = ($countones(pattern_i) == 1);
  assign idx_o   = IDX_W'(onehot_idx(MAX_W'(pattern_i)));

endmodule

// File: rtl/ring_decoder.sv
// Receive-side checker for the one-hot ring counter bus: verifies each valid
// sample is one rotation step on from the last, locks, and reports idx/lap/err.
module ring_decoder
  import ring_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 3,
  parameter bit ROT_LEFT = 1'b1,
  parameter int ERR_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         ring_in,
  input  logic                     ring_vld,
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic                     idx_vld,
  output logic                     locked,
  output logic                     lap,
  output logic                     err,
  output logic [ERR_W-1:0]         err_cnt
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = clog2(LOCK_CNT + 1);
  localparam logic [WIDTH-1:0] START = ROT_LEFT ? WIDTH'(1) : (WIDTH'(1) << (WIDTH - 1));

  ring_state_e      state_q;
  logic [CNT_W-1:0] goodCnt_q;
  logic [WIDTH-1:0] prev_q;
  logic [IDX_W-1:0] idx_q;
  logic             idxVld_q;
  logic             lap_q;
  logic             err_q;
  logic [ERR_W-1:0] errCnt_q;

  logic [IDX_W-1:0] encIdx;
  logic             encLegal;
  logic [WIDTH-1:0] expect_d;
  logic             stepOk;
  logic             errNow;
  logic [ERR_W-1:0] errCnt_d;

  ring_onehot_enc #(
    .WIDTH(WIDTH),
    .IDX_W(IDX_W)
  ) u_enc (
    .pattern_i(ring_in),
    .idx_o    (encIdx),
    .legal_o  (encLegal)
  );

  // prev_q is zero after reset, so its rotation never matches a legal sample.
  assign expect_d = WIDTH'(rotate(MAX_W'(prev_q), WIDTH, ROT_LEFT));
  assign stepOk   = encLegal && (ring_in == expect_d);
  assign errNow   = ring_vld && ((state_q == HUNT) ? !encLegal : !stepOk);
  assign errCnt_d = (errCnt_q == '1) ? errCnt_q : errCnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HUNT;
      goodCnt_q <= '0;
      prev_q    <= '0;
      idx_q     <= '0;
      idxVld_q  <= 1'b0;
      lap_q     <= 1'b0;
      err_q     <= 1'b0;
      errCnt_q  <= '0;
    end else begin
      idxVld_q <= 1'b0;
      lap_q    <= 1'b0;
      err_q    <= errNow;
      if (errNow) errCnt_q <= errCnt_d;
      if (ring_vld) begin
        if (encLegal) begin
          idx_q    <= encIdx;
          idxVld_q <= 1'b1;
          prev_q   <= ring_in;
        end
        case (state_q)
          HUNT: begin
            if (!stepOk) begin
              goodCnt_q <= '0;
            end else if (goodCnt_q == CNT_W'(LOCK_CNT - 1)) begin
              goodCnt_q <= '0;
              state_q   <= LOCKED;
            end else begin
              goodCnt_q <= goodCnt_q + 1'b1;
            end
          end
          LOCKED: begin
            if (stepOk) begin
              lap_q <= (ring_in == START);
            end else begin
              state_q   <= HUNT;
              goodCnt_q <= '0;
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign idx     = idx_q;
  assign idx_vld = idxVld_q;
  assign locked  = (state_q == LOCKED);
  assign lap     = lap_q;
  assign err     = err_q;
  assign err_cnt = errCnt_q;

endmodule

// File: tb/tb_ring_decoder.sv
// Self-checking bench for ring_decoder against an index-arithmetic model of
// the ring protocol (WIDTH=4, LOCK_CNT=3, ROT_LEFT=1, ERR_W=8).
module tb_ring_decoder;

  localparam int W    = 4;
  localparam int LC   = 3;
  localparam int ERRW = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] ring_in;
  logic         ring_vld;
  logic [1:0]   idx;
  logic         idx_vld;
  logic         locked;
  logic         lap;
  logic         err;
  logic [7:0]   err_cnt;

  int nVectors = 0;
  int nMiscompares = 0;

  // Model state: prevPos is the bit index of the last legal sample, -1 if none.
  int mPrev, mGood, mIdx, mErrCnt;
  bit mLocked, mIdxVld, mLap, mErr;

  logic [13:0] actV, expV;

  always #5 clk = ~clk;

  ring_decoder #(
    .WIDTH   (W),
    .LOCK_CNT(LC),
    .ROT_LEFT(1'b1),
    .ERR_W   (ERRW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ring_in (ring_in),
    .ring_vld(ring_vld),
    .idx     (idx),
    .idx_vld (idx_vld),
    .locked  (locked),
    .lap     (lap),
    .err     (err),
    .err_cnt (err_cnt)
  );

  function automatic logic [13:0] expected();
    return {2'(mIdx), mIdxVld, mLocked, mLap, mErr, 8'(mErrCnt)};
  endfunction

  // Drive one cycle and advance the model by the protocol rules.
  task automatic drive(input logic [W-1:0] r, input logic v, input logic rs);
    bit legalS, stepS;
    int pos;
    @(negedge clk);
    ring_in  = r;
    ring_vld = v;
    rst      = rs;
    @(posedge clk);
    #1;
    mIdxVld = 0; mLap = 0; mErr = 0;
    if (rs) begin
      mPrev = -1; mGood = 0; mIdx = 0; mErrCnt = 0; mLocked = 0;
    end else if (v) begin
      legalS = ($countones(r) == 1);
      pos = 0;
      for (int i = 0; i < W; i++) if (r[i]) pos = i;
      stepS = legalS && (mPrev >= 0) && (pos == (mPrev + 1) % W);
      if (legalS) begin mIdx = pos; mIdxVld = 1; end
      if (!mLocked) begin
        if (!legalS) begin
          mErr = 1; mGood = 0;
        end else if (!stepS) begin
          mGood = 0; mPrev = pos;
        end else begin
          mPrev = pos; mGood++;
          if (mGood == LC) begin mLocked = 1; mGood = 0; end
        end
      end else begin
        if (stepS) begin
          mPrev = pos; mLap = (pos == 0);
        end else begin
          mErr = 1; mLocked = 0; mGood = 0;
          if (legalS) mPrev = pos;
        end
      end
      if (mErr && mErrCnt < 255) mErrCnt++;
    end
  endtask

  task automatic test_reset();
    drive(4'b0001, 1'b1, 1'b1);
    drive(4'b0000, 1'b0, 1'b1);
    actV = {idx, idx_vld, locked, lap, err, err_cnt};
    expV = expected();
    nVectors++;
    if (actV !== expV || actV !== 14'd0) begin
      nMiscompares++;
      $display("[TB] FAIL reset: got %h expected %h", actV, expV);
    end
  endtask

  task automatic test_lock();
    logic [W-1:0] seq [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < 4; i++) begin
      drive(seq[i], 1'b1, 1'b0);
      actV = {idx, idx_vld, locked, lap, err, err_cnt};
      expV = expected();
      nVectors++;
      if (actV !== expV || idx !== 2'(i) || locked !== (i == 3)) begin
        nMiscompares++;
        $display("[TB] FAIL lock step %0d: got %h expected %h", i, actV, expV);
      end
    end
  endtask

  task automatic test_lap();
    int laps = 0;
    for (int i = 0; i < 8; i++) begin
      drive(4'b0001 << (i % 4), 1'b1, 1'b0);
      laps += int'(lap);
      actV = {idx, idx_vld, locked, lap, err, err_cnt};
      expV = expected();
      nVectors++;
      if (actV !== expV) begin
        nMiscompares++;
        $display("[TB] FAIL lap cycle %0d: got %h expected %h", i, actV, expV);
      end
    end
    nVectors++;
    if (laps !== 2) begin
      nMiscompares++;
      $display("[TB] FAIL lap count: got %0d expected 2", laps);
    end
  endtask

  task automatic test_illegal_in_lock();
    logic [W-1:0] seq [5] = '{4'b0110, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    for (int i = 0; i < 5; i++) begin
      drive(seq[i], 1'b1, 1'b0);
      actV = {idx, idx_vld, locked, lap, err, err_cnt};
      expV = expected();
      nVectors++;
      if (actV !== expV) begin
        nMiscompares++;
        $display("[TB] FAIL illegal %0d: got %h expected %h", i, actV, expV);
      end
    end
  endtask

  task automatic test_stall_and_idle();
    logic [W-1:0] seq [5] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0010};
    for (int i = 0; i < 5; i++) begin
      drive(seq[i], 1'b1, 1'b0);
      actV = {idx, idx_vld, locked, lap, err, err_cnt};
      expV = expected();
      nVectors++;
      if (actV !== expV) begin
        nMiscompares++;
        $display("[TB] FAIL stall %0d: got %h expected %h", i, actV, expV);
      end
    end
    for (int i = 0; i < 5; i++) begin
      drive(4'($urandom_range(0, 15)), 1'b0, 1'b0);
      actV = {idx, idx_vld, locked, lap, err, err_cnt};
      expV = expected();
      nVectors++;
      if (actV !== expV) begin
        nMiscompares++;
        $display("[TB] FAIL idle %0d: got %h expected %h", i, actV, expV);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] r;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 7)
        r = (mPrev < 0) ? 4'b0001 : 4'(1 << ((mPrev + 1) % W));
      else
        r = 4'($urandom_range(0, 15));
      drive(r, ($urandom_range(0, 7) != 0), ($urandom_range(0, 49) == 0));
      actV = {idx, idx_vld, locked, lap, err, err_cnt};
      expV = expected();
      nVectors++;
      if (actV !== expV) begin
        nMiscompares++;
        $display("[TB] FAIL random %0d ring=%b: got %h expected %h", i, r, actV, expV);
      end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 260; i++) begin
      drive(4'b0000, 1'b1, 1'b0);
      actV = {idx, idx_vld, locked, lap, err, err_cnt};
      expV = expected();
      nVectors++;
      if (actV !== expV) begin
        nMiscompares++;
        $display("[TB] FAIL saturate %0d: got %h expected %h", i, actV, expV);
      end
    end
    nVectors++;
    if (err_cnt !== 8'd255) begin
      nMiscompares++;
      $display("[TB] FAIL err_cnt final: got %0d expected 255", err_cnt);
    end
  endtask

  task automatic test_reset_mid_lock();
    logic [W-1:0] seq [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                              4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < 4; i++) drive(seq[i], 1'b1, 1'b0);
    nVectors++;
    if (locked !== mLocked || locked !== 1'b1) begin
      nMiscompares++;
      $display("[TB] FAIL pre-reset lock: got %b expected 1", locked);
    end
    drive(4'b0001, 1'b1, 1'b1);
    actV = {idx, idx_vld, locked, lap, err, err_cnt};
    expV = expected();
    nVectors++;
    if (actV !== expV || actV !== 14'd0) begin
      nMiscompares++;
      $display("[TB] FAIL reset mid-lock: got %h expected %h", actV, expV);
    end
    for (int i = 4; i < 8; i++) begin
      drive(seq[i], 1'b1, 1'b0);
      actV = {idx, idx_vld, locked, lap, err, err_cnt};
      expV = expected();
      nVectors++;
      if (actV !== expV) begin
        nMiscompares++;
        $display("[TB] FAIL relock %0d: got %h expected %h", i, actV, expV);
      end
    end
  endtask

  initial begin
    rst = 1'b1; ring_in = '0; ring_vld = 1'b0;
    mPrev = -1; mGood = 0; mIdx = 0; mErrCnt = 0;
    mLocked = 0; mIdxVld = 0; mLap = 0; mErr = 0;
    test_reset();
    test_lock();
    test_lap();
    test_illegal_in_lock();
    test_stall_and_idle();
    test_random();
    test_saturation();
    test_reset_mid_lock();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
